// File: rtl/gbf_fill_scheduler.sv
// Global-buffer fill scheduler: arbitrates four GBF fill requests and streams FILL_LEN beats into the granted buffer.
// Optional macro GBF_FILL_SCHED_WGT_PRIORITY_EN selects fixed weight-first priority instead of round-robin.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for an eligible request while finish is low
// S_GRANT | pick winner, latch ext_req_id, clear beat counter
// S_FILL  | accept FILL_LEN beats and write them to the granted buffer
// S_DONE  | buf_ready pulse visible, mark buffer served, back to idle
module gbf_fill_scheduler #(
   parameter int GBF_DATA_BITWIDTH = 512,
   parameter int GBF_ADDR_BITWIDTH = 5,
   parameter int FILL_LEN          = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [3:0]                   need_data,
   input  logic                         finish,
   input  logic                         ext_valid,
   input  logic [GBF_DATA_BITWIDTH-1:0] ext_data,
   output logic                         ext_ready,
   output logic [1:0]                   ext_req_id,
   output logic [3:0]                   fill_en,
   output logic [GBF_ADDR_BITWIDTH-1:0] fill_addr,
   output logic [GBF_DATA_BITWIDTH-1:0] fill_w_data,
   output logic [3:0]                   buf_ready,
   output logic                         busy
);

   localparam int CW = GBF_ADDR_BITWIDTH + 1;
   localparam logic [CW-1:0] BEATS     = CW'(FILL_LEN);
   localparam logic [CW-1:0] LAST_BEAT = CW'(FILL_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_FILL, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [3:0]      served;
   logic [3:0]      eligible;
   logic [3:0]      elig_q;
   logic [1:0]      rr_last;
   logic [1:0]      winner;
   logic [CW-1:0]   beat_cnt;
   logic            accept;
   logic            last_accept;

   assign eligible    = need_data & ~served;
   assign ext_ready   = (state == S_FILL) && (beat_cnt < BEATS);
   assign accept      = ext_valid && ext_ready;
   assign last_accept = accept && (beat_cnt == LAST_BEAT);
   assign busy        = (state == S_GRANT) || (state == S_FILL);

`ifdef GBF_FILL_SCHED_WGT_PRIORITY_EN
   always_comb begin
      winner = 2'd1;
      if (elig_q[2])      winner = 2'd2;
      else if (elig_q[3]) winner = 2'd3;
      else if (elig_q[0]) winner = 2'd0;
   end
`else
   // Scan from farthest to nearest so the index right after rr_last wins.
   always_comb begin
      winner = rr_last;
      for (int k = 4; k >= 1; k--) begin
         if (elig_q[2'(rr_last + 2'(k))]) winner = 2'(rr_last + 2'(k));
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!finish && (|eligible)) state_nxt = S_GRANT;
         S_GRANT: state_nxt = S_FILL;
         S_FILL:  if (last_accept) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         served      <= 4'b0;
         elig_q      <= 4'b0;
         rr_last     <= 2'd3;
         beat_cnt    <= '0;
         ext_req_id  <= 2'd0;
         fill_en     <= 4'b0;
         fill_addr   <= '0;
         fill_w_data <= '0;
         buf_ready   <= 4'b0;
      end else begin
         state     <= state_nxt;
         fill_en   <= 4'b0;
         buf_ready <= 4'b0;
         // A dropped request always clears its served flag, even mid-fill.
         served    <= (served | ((state == S_DONE) ? (4'b0001 << ext_req_id) : 4'b0)) & need_data;
         if (state == S_IDLE) elig_q <= eligible;
         if (state == S_GRANT) begin
            ext_req_id <= winner;
            rr_last    <= winner;
            beat_cnt   <= '0;
         end
         if (accept) begin
            fill_en     <= 4'b0001 << ext_req_id;
            fill_addr   <= beat_cnt[GBF_ADDR_BITWIDTH-1:0];
            fill_w_data <= ext_data;
            beat_cnt    <= beat_cnt + 1'b1;
         end
         if (last_accept) buf_ready <= 4'b0001 << ext_req_id;
      end
   end

endmodule

// File: tb/tb_gbf_fill_scheduler.sv
// Scoreboard bench for gbf_fill_scheduler: a request/arbitration model predicts every GBF write,
// a monitor compares each presented write and buf_ready pulse against the expected queue.
module tb_gbf_fill_scheduler;
   localparam int W = 512;
   localparam int A = 5;
   localparam int L = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    need_data;
   logic          finish;
   logic          ext_valid;
   logic [W-1:0]  ext_data;
   logic          ext_ready;
   logic [1:0]    ext_req_id;
   logic [3:0]    fill_en;
   logic [A-1:0]  fill_addr;
   logic [W-1:0]  fill_w_data;
   logic [3:0]    buf_ready;
   logic          busy;

   gbf_fill_scheduler #(.GBF_DATA_BITWIDTH(W), .GBF_ADDR_BITWIDTH(A), .FILL_LEN(L)) dut (
      .clk(clk), .reset(reset), .need_data(need_data), .finish(finish),
      .ext_valid(ext_valid), .ext_data(ext_data), .ext_ready(ext_ready),
      .ext_req_id(ext_req_id), .fill_en(fill_en), .fill_addr(fill_addr),
      .fill_w_data(fill_w_data), .buf_ready(buf_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           id;
      int           addr;
      logic [W-1:0] data;
      bit           last;
   } beat_t;

   int         checks = 0;
   int         errors = 0;
   beat_t      exp_q[$];
   int         obs_order[$];
   int         beat_seen = 0;

   // Reference model: which buffers are served, who was granted last, progress of current fill.
   logic [3:0] m_served;
   int         m_last;
   int         m_cur;
   int         m_beat;
   bit         m_in_fill;

   task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int pick(logic [3:0] need, logic [3:0] srv, int last);
      logic [3:0] e = need & ~srv;
`ifdef GBF_FILL_SCHED_WGT_PRIORITY_EN
      int ord[4] = '{2, 3, 0, 1};
      for (int i = 0; i < 4; i++) if (e[ord[i]]) return ord[i];
`else
      for (int k = 1; k <= 4; k++) if (e[(last + k) % 4]) return (last + k) % 4;
`endif
      return -1;
   endfunction

   function automatic logic [W-1:0] rnd_data();
      logic [W-1:0] d;
      for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic model_reset();
      m_served  = 4'b0;
      m_last    = 3;
      m_cur     = 0;
      m_beat    = 0;
      m_in_fill = 0;
      exp_q.delete();
   endtask

   // One cycle of stimulus; predicts the write produced by a handshake at the coming edge.
   task automatic step(bit v);
      beat_t b;
      @(negedge clk);
      ext_valid = v;
      ext_data  = rnd_data();
      m_served  = m_served & need_data;
      #1;
      if (ext_valid && ext_ready) begin
         if (!m_in_fill) begin
            m_cur = pick(need_data, m_served, m_last);
            check("grant_eligible", (m_cur >= 0), 1);
            if (m_cur < 0) m_cur = 0;
            m_last    = m_cur;
            m_in_fill = 1;
            m_beat    = 0;
         end
         check("ext_req_id", ext_req_id, m_cur);
         b.id = m_cur; b.addr = m_beat; b.data = ext_data; b.last = (m_beat == L - 1);
         exp_q.push_back(b);
         m_beat++;
         if (m_beat == L) begin
            m_served[m_cur] = 1'b1;
            m_in_fill = 0;
            m_beat = 0;
         end
      end
   endtask

   task automatic run(int n, int mode);
      // mode 0: valid held high, 1: alternate 1,0,.., 2: random ~75% valid
      for (int i = 0; i < n; i++) begin
         if (mode == 0)      step(1'b1);
         else if (mode == 1) step(i % 2 == 0);
         else                step($urandom_range(3) != 0);
      end
   endtask

   task automatic do_reset(bit check_outputs);
      @(negedge clk);
      reset = 1'b1;
      ext_valid = 1'b0;
      #1;
      if (check_outputs) begin
         check("rst_ext_ready", ext_ready, 0);
         check("rst_fill_en", fill_en, 0);
         check("rst_buf_ready", buf_ready, 0);
         check("rst_busy", busy, 0);
         check("rst_ext_req_id", ext_req_id, 0);
         check("rst_fill_addr", fill_addr, 0);
         check("rst_fill_w_data", fill_w_data, 0);
         check("rst_queue_drained", exp_q.size(), 0);
      end
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Monitor: compares every presented write and completion pulse against the scoreboard.
   beat_t mon_b;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (reset) continue;
         if (fill_en != 4'b0) begin
            beat_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write fill_en=%b addr=%0d expected none", fill_en, fill_addr);
            end else begin
               mon_b = exp_q.pop_front();
               check("fill_en", fill_en, 4'b0001 << mon_b.id);
               check("fill_addr", fill_addr, mon_b.addr);
               check("fill_w_data", fill_w_data, mon_b.data);
               check("buf_ready", buf_ready, mon_b.last ? (4'b0001 << mon_b.id) : 4'b0);
            end
         end else if (buf_ready != 4'b0) begin
            checks++;
            errors++;
            $display("FAIL stray_buf_ready buf_ready=%b required=0000", buf_ready);
         end
         for (int i = 0; i < 4; i++) if (buf_ready[i]) obs_order.push_back(i);
      end
   end

   int base_beats;
   int base_done;
   int exp_order[4];
   logic [3:0] rnd_need;

   initial begin
      reset = 1'b1; need_data = 4'b0; finish = 1'b0; ext_valid = 1'b0; ext_data = '0;
      model_reset();
      #1;
      check("init_busy", busy, 0);
      check("init_fill_en", fill_en, 0);
      check("init_ext_ready", ext_ready, 0);
      check("init_buf_ready", buf_ready, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Single buffer, continuous stream.
      need_data = 4'b0001;
      base_beats = beat_seen;
      run(40, 0);
      check("single_beats", beat_seen - base_beats, L);
      check("single_done_cnt", obs_order.size(), 1);
      if (obs_order.size() > 0) check("single_done_id", obs_order[0], 0);
      check("single_idle", busy, 0);

      // Held request is not regranted; a one-cycle drop re-arms it.
      run(50, 0);
      check("held_no_regrant", obs_order.size(), 1);
      need_data = 4'b0000;
      step(1'b1);
      need_data = 4'b0001;
      run(45, 0);
      check("rearm_regrant", obs_order.size(), 2);
      need_data = 4'b0000;
      run(3, 0);

      // All four requests from reset: grant order.
      do_reset(1'b0);
      obs_order.delete();
`ifdef GBF_FILL_SCHED_WGT_PRIORITY_EN
      exp_order = '{2, 3, 0, 1};
`else
      exp_order = '{0, 1, 2, 3};
`endif
      need_data = 4'b1111;
      run(4 * 40 + 10, 0);
      check("all4_done_cnt", obs_order.size(), 4);
      for (int i = 0; i < 4; i++) if (i < obs_order.size()) check("all4_order", obs_order[i], exp_order[i]);
      run(50, 0);
      check("all4_no_regrant", obs_order.size(), 4);
      need_data = 4'b0000;
      run(3, 0);

      // Alternating ext_valid gaps.
      need_data = 4'b0100;
      base_beats = beat_seen;
      base_done = obs_order.size();
      run(80, 1);
      check("gap_beats", beat_seen - base_beats, L);
      check("gap_done", obs_order.size() - base_done, 1);
      need_data = 4'b0000;
      run(3, 0);

      // Random request sets and random valid gaps.
      for (int s = 0; s < 3; s++) begin
         rnd_need = 4'($urandom_range(1, 15));
         base_done = obs_order.size();
         need_data = rnd_need;
         run(4 * 50 + 20, 2);
         check("rand_done_cnt", obs_order.size() - base_done, $countones(rnd_need));
         check("rand_idle", busy, 0);
         need_data = 4'b0000;
         run(3, 0);
      end
      check("rand_queue_empty", exp_q.size(), 0);

      // finish raised mid-fill: current fill completes, next grant held off.
      do_reset(1'b0);
      obs_order.delete();
      need_data = 4'b0011;
      for (int i = 0; i < 30 && !(m_in_fill && m_beat == 5); i++) step(1'b1);
      check("fin_beat5_reached", m_beat, 5);
      finish = 1'b1;
      run(60, 0);
      check("fin_buf0_done", obs_order.size(), 1);
      if (obs_order.size() > 0) check("fin_buf0_id", obs_order[0], 0);
      check("fin_no_grant", busy, 0);
      finish = 1'b0;
      run(45, 0);
      check("fin_buf1_done", obs_order.size(), 2);
      if (obs_order.size() > 1) check("fin_buf1_id", obs_order[1], 1);
      need_data = 4'b0000;
      run(3, 0);

      // Reset in the middle of a fill, then restart from address 0.
      do_reset(1'b0);
      obs_order.delete();
      need_data = 4'b0001;
      for (int i = 0; i < 30 && !(m_in_fill && m_beat == 10); i++) step(1'b1);
      check("mid_beat10_reached", m_beat, 10);
      do_reset(1'b1);
      check("mid_no_buf_ready", obs_order.size(), 0);
      base_beats = beat_seen;
      run(45, 0);
      check("mid_restart_beats", beat_seen - base_beats, L);
      check("mid_restart_done", obs_order.size(), 1);
      check("final_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
